// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock_pkg
//  Description : Shared types, BCD limits and load validation for the
//                multi-alarm time-of-day clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } al_state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    localparam logic [1:0] HR_MAX_T      = 2'd2;
    localparam logic [3:0] HR_MAX_U_AT_2 = 4'd3;
    localparam logic [3:0] MIN_MAX_T     = 4'd5;
    localparam logic [3:0] DIG_MAX       = 4'd9;

    function automatic logic hhmm_valid(input hhmm_t t);
        logic hr_ok;
        hr_ok = ((t.h1 < HR_MAX_T) && (t.h0 <= DIG_MAX)) ||
                ((t.h1 == HR_MAX_T) && (t.h0 <= HR_MAX_U_AT_2));
        return hr_ok && (t.m1 <= MIN_MAX_T) && (t.m0 <= DIG_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_alarm_clock_bcd_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_time_counter
//  Description : 24-hour BCD HH:MM:SS counter with synchronous load.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_counter
    import alarm_clock_pkg::*;
(
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       ld,
    input  hhmm_t      ld_val,
    output logic [1:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       sec_zero
);

    logic [1:0] h1_q, h1_d;
    logic [3:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;

    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;
        if (ld) begin
            h1_d = ld_val.h1;
            h0_d = ld_val.h0;
            m1_d = ld_val.m1;
            m0_d = ld_val.m0;
            s1_d = 4'd0;
            s0_d = 4'd0;
        end else if (s0_q != DIG_MAX) begin
            s0_d = s0_q + 4'd1;
        end else begin
            s0_d = 4'd0;
            if (s1_q != MIN_MAX_T) begin
                s1_d = s1_q + 4'd1;
            end else begin
                s1_d = 4'd0;
                if (m0_q != DIG_MAX) begin
                    m0_d = m0_q + 4'd1;
                end else begin
                    m0_d = 4'd0;
                    if (m1_q != MIN_MAX_T) begin
                        m1_d = m1_q + 4'd1;
                    end else begin
                        m1_d = 4'd0;
                        // Hour units roll at 9 normally but at 3 when tens is 2
                        if ((h1_q == HR_MAX_T) && (h0_q == HR_MAX_U_AT_2)) begin
                            h1_d = 2'd0;
                            h0_d = 4'd0;
                        end else if (h0_q == DIG_MAX) begin
                            h0_d = 4'd0;
                            h1_d = h1_q + 2'd1;
                        end else begin
                            h0_d = h0_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            h1_q <= 2'd0;
            h0_q <= 4'd0;
            m1_q <= 4'd0;
            m0_q <= 4'd0;
            s1_q <= 4'd0;
            s0_q <= 4'd0;
        end else begin
            h1_q <= h1_d;
            h0_q <= h0_d;
            m1_q <= m1_d;
            m0_q <= m0_d;
            s1_q <= s1_d;
            s0_q <= s0_d;
        end
    end

    assign h1       = h1_q;
    assign h0       = h0_q;
    assign m1       = m1_q;
    assign m0       = m0_q;
    assign s1       = s1_q;
    assign s0       = s0_q;
    assign sec_zero = (s1_q == 4'd0) && (s0_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
//  Module      : multi_alarm_clock
//  Description : BCD time-of-day clock with NUM_ALARMS programmable alarm
//                slots, snooze and ring auto-timeout, clocked at 1 Hz.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter  int NUM_ALARMS = 4,
    parameter  int SNOOZE_SEC = 300,
    parameter  int RING_SEC   = 60,
    localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk_1s,
    input  logic          reset,
    input  logic [1:0]    h_in1,
    input  logic [3:0]    h_in0,
    input  logic [3:0]    m_in1,
    input  logic [3:0]    m_in0,
    input  logic          ld_time,
    input  logic          ld_alarm,
    input  logic [AW-1:0] al_sel,
    input  logic          al_en_in,
    input  logic          stop_al,
    input  logic          snooze,
    output logic          alarm,
    output logic [AW-1:0] alarm_idx,
    output logic          snoozed,
    output logic          ld_err,
    output logic [1:0]    h_out1,
    output logic [3:0]    h_out0,
    output logic [3:0]    m_out1,
    output logic [3:0]    m_out0,
    output logic [3:0]    s_out1,
    output logic [3:0]    s_out0
);

    localparam int            CNT_MAX     = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
    localparam int            CW          = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] RING_LOAD   = CW'(RING_SEC - 1);
    localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_SEC - 1);
    localparam logic [AW:0]   NUM_AL_W    = NUM_ALARMS[AW:0];

    hhmm_t   in_hhmm, cur_hhmm;
    logic    in_valid, sel_ok, time_ld, alarm_wr, sec_zero;

    assign in_hhmm  = {h_in1, h_in0, m_in1, m_in0};
    assign in_valid = hhmm_valid(in_hhmm);
    assign sel_ok   = ({1'b0, al_sel} < NUM_AL_W);
    assign time_ld  = ld_time & in_valid;
    assign alarm_wr = ld_alarm & in_valid & sel_ok;

    bcd_time_counter u_time (
        .clk_1s   (clk_1s),
        .reset    (reset),
        .ld       (time_ld),
        .ld_val   (in_hhmm),
        .h1       (h_out1),
        .h0       (h_out0),
        .m1       (m_out1),
        .m0       (m_out0),
        .s1       (s_out1),
        .s0       (s_out0),
        .sec_zero (sec_zero)
    );

    assign cur_hhmm = {h_out1, h_out0, m_out1, m_out0};

    hhmm_t                 slot_q [NUM_ALARMS];
    hhmm_t                 slot_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q, en_d;

    always_comb begin
        slot_d = slot_q;
        en_d   = en_q;
        if (alarm_wr) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (al_sel == AW'(i)) begin
                    slot_d[i] = in_hhmm;
                    en_d[i]   = al_en_in;
                end
            end
        end
    end

    // Descending scan so the lowest matching index is the one left standing
    logic          match;
    logic [AW-1:0] match_idx;

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (en_q[i] && (slot_q[i] == cur_hhmm)) begin
                match     = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    al_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] alarm_idx_q, alarm_idx_d;
    logic          alarm_q, alarm_d, snoozed_q, snoozed_d, ld_err_q, ld_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alarm_idx_d = alarm_idx_q;
        case (state_q)
            IDLE: begin
                if (sec_zero && match && !ld_time) begin
                    state_d     = RINGING;
                    cnt_d       = RING_LOAD;
                    alarm_idx_d = match_idx;
                end
            end
            RINGING: begin
                if (stop_al) begin
                    state_d = IDLE;
                end else if (snooze) begin
                    state_d = SNOOZED;
                    cnt_d   = SNOOZE_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SNOOZED: begin
                if (stop_al) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RINGING;
                    cnt_d   = RING_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        alarm_d   = (state_d == RINGING);
        snoozed_d = (state_d == SNOOZED);
        ld_err_d  = (ld_time & ~in_valid) | (ld_alarm & ~(in_valid & sel_ok));
    end

    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_q[i] <= '0;
            end
            en_q        <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            alarm_idx_q <= '0;
            alarm_q     <= 1'b0;
            snoozed_q   <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            en_q        <= en_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alarm_idx_q <= alarm_idx_d;
            alarm_q     <= alarm_d;
            snoozed_q   <= snoozed_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign alarm     = alarm_q;
    assign snoozed   = snoozed_q;
    assign alarm_idx = alarm_idx_q;
    assign ld_err    = ld_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_alarm_clock
//  Description : Directed, self-checking bench for multi_alarm_clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_alarm_clock;

    logic       clk_1s = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] h_in1  = '0;
    logic [3:0] h_in0  = '0, m_in1 = '0, m_in0 = '0;
    logic       ld_time = 1'b0, ld_alarm = 1'b0, al_en_in = 1'b0;
    logic [1:0] al_sel = '0;
    logic       stop_al = 1'b0, snooze = 1'b0;
    logic       alarm, snoozed, ld_err;
    logic [1:0] alarm_idx;
    logic [1:0] h_out1;
    logic [3:0] h_out0, m_out1, m_out0, s_out1, s_out0;

    int passed = 0;
    int total  = 0;

    always #5 clk_1s = ~clk_1s;

    multi_alarm_clock #(.NUM_ALARMS(4), .SNOOZE_SEC(300), .RING_SEC(60)) dut (
        .clk_1s(clk_1s), .reset(reset),
        .h_in1(h_in1), .h_in0(h_in0), .m_in1(m_in1), .m_in0(m_in0),
        .ld_time(ld_time), .ld_alarm(ld_alarm), .al_sel(al_sel), .al_en_in(al_en_in),
        .stop_al(stop_al), .snooze(snooze),
        .alarm(alarm), .alarm_idx(alarm_idx), .snoozed(snoozed), .ld_err(ld_err),
        .h_out1(h_out1), .h_out0(h_out0), .m_out1(m_out1), .m_out0(m_out0),
        .s_out1(s_out1), .s_out0(s_out0)
    );

    wire [21:0] disp = {h_out1, h_out0, m_out1, m_out0, s_out1, s_out0};

    function automatic logic [21:0] bcd(input int h, input int m, input int s);
        logic [1:0] a;
        logic [3:0] b, c, d, e, f;
        a = 2'(h / 10); b = 4'(h % 10);
        c = 4'(m / 10); d = 4'(m % 10);
        e = 4'(s / 10); f = 4'(s % 10);
        return {a, b, c, d, e, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_1s);
        @(negedge clk_1s);
    endtask

    task automatic drive_hhmm(input int h, input int m);
        h_in1 = 2'(h / 10); h_in0 = 4'(h % 10);
        m_in1 = 4'(m / 10); m_in0 = 4'(m % 10);
    endtask

    task automatic write_slot(input int sel, input int h, input int m, input logic en);
        drive_hhmm(h, m);
        al_sel = 2'(sel); al_en_in = en; ld_alarm = 1'b1;
        step();
        ld_alarm = 1'b0;
    endtask

    // Load lh:lm (one minute before th:tm), run to th:tm:00 and into the ring
    task automatic do_ring(input string name, input int lh, input int lm,
                           input int th, input int tm, input int exp_idx);
        drive_hhmm(lh, lm); ld_time = 1'b1;
        step();
        ld_time = 1'b0;
        repeat (60) step();
        check({name, "_at_00"}, {10'd0, disp}, {10'd0, bcd(th, tm, 0)});
        check({name, "_quiet_at_00"}, {31'd0, alarm}, 32'd0);
        step();
        check({name, "_ring_at_01"}, {31'd0, alarm}, 32'd1);
        check({name, "_idx"}, {30'd0, alarm_idx}, exp_idx);
    endtask

    typedef struct {
        logic        lt;
        logic        la;
        logic [1:0]  h1;
        logic [3:0]  h0;
        logic [3:0]  m1;
        logic [3:0]  m0;
        logic [1:0]  sel;
        logic        en;
        logic        exp_err;
        logic [21:0] exp_time;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int   ring_cnt;
        int   low_cnt;
        logic any_alarm;

        vecs[0] = '{1'b1, 1'b0, 2'd1, 4'd2, 4'd3, 4'd4,  2'd0, 1'b0, 1'b0, bcd(12, 34, 0)};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 4'd4, 4'd0, 4'd0,  2'd0, 1'b0, 1'b1, bcd(12, 34, 1)};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 4'd10, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1, bcd(12, 34, 2)};
        vecs[3] = '{1'b1, 1'b0, 2'd2, 4'd3, 4'd6, 4'd0,  2'd0, 1'b0, 1'b1, bcd(12, 34, 3)};
        vecs[4] = '{1'b1, 1'b0, 2'd2, 4'd3, 4'd5, 4'd9,  2'd0, 1'b0, 1'b0, bcd(23, 59, 0)};
        vecs[5] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0,  2'd0, 1'b0, 1'b0, bcd(23, 59, 1)};
        vecs[6] = '{1'b0, 1'b1, 2'd0, 4'd8, 4'd0, 4'd0,  2'd0, 1'b1, 1'b0, bcd(23, 59, 2)};
        vecs[7] = '{1'b0, 1'b1, 2'd1, 4'd2, 4'd6, 4'd0,  2'd0, 1'b0, 1'b1, bcd(23, 59, 3)};
        vecs[8] = '{1'b1, 1'b1, 2'd0, 4'd7, 4'd5, 4'd9,  2'd3, 1'b0, 1'b0, bcd(7, 59, 0)};
        vecs[9] = '{1'b0, 1'b1, 2'd0, 4'd7, 4'd5, 4'd15, 2'd1, 1'b1, 1'b1, bcd(7, 59, 1)};

        // Reset state
        @(negedge clk_1s);
        check("rst_time", {10'd0, disp}, 32'd0);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        check("rst_snoozed", {31'd0, snoozed}, 32'd0);
        check("rst_idx", {30'd0, alarm_idx}, 32'd0);
        check("rst_ld_err", {31'd0, ld_err}, 32'd0);
        reset = 1'b0;

        // A full day with every slot disabled
        any_alarm = 1'b0;
        for (int i = 1; i <= 86400; i++) begin
            step();
            any_alarm = any_alarm | alarm | snoozed;
            if (i == 59)    check("day_00_00_59", {10'd0, disp}, {10'd0, bcd(0, 0, 59)});
            if (i == 60)    check("day_00_01_00", {10'd0, disp}, {10'd0, bcd(0, 1, 0)});
            if (i == 3600)  check("day_01_00_00", {10'd0, disp}, {10'd0, bcd(1, 0, 0)});
            if (i == 86399) check("day_23_59_59", {10'd0, disp}, {10'd0, bcd(23, 59, 59)});
            if (i == 86400) check("day_wrap", {10'd0, disp}, {10'd0, bcd(0, 0, 0)});
        end
        check("day_no_alarm", {31'd0, any_alarm}, 32'd0);

        // Load / validation vectors, one clock each
        for (int v = 0; v < 10; v++) begin
            ld_time = vecs[v].lt; ld_alarm = vecs[v].la;
            h_in1 = vecs[v].h1; h_in0 = vecs[v].h0; m_in1 = vecs[v].m1; m_in0 = vecs[v].m0;
            al_sel = vecs[v].sel; al_en_in = vecs[v].en;
            step();
            check($sformatf("vec%0d_ld_err", v), {31'd0, ld_err}, {31'd0, vecs[v].exp_err});
            check($sformatf("vec%0d_time", v), {10'd0, disp}, {10'd0, vecs[v].exp_time});
            check($sformatf("vec%0d_alarm", v), {31'd0, alarm}, 32'd0);
        end
        ld_time = 1'b0; ld_alarm = 1'b0;

        // Slot 0 = 08:00 survived the rejected write; time now 07:59:01
        repeat (59) step();
        check("s0_at_08_00_00", {10'd0, disp}, {10'd0, bcd(8, 0, 0)});
        check("s0_quiet_at_00", {31'd0, alarm}, 32'd0);
        step();
        check("s0_ring", {31'd0, alarm}, 32'd1);
        check("s0_idx", {30'd0, alarm_idx}, 32'd0);
        stop_al = 1'b1; step(); stop_al = 1'b0;
        check("s0_stop_alarm", {31'd0, alarm}, 32'd0);

        // Slot 2 = 07:30, full ring length
        write_slot(2, 7, 30, 1'b1);
        do_ring("s2", 7, 29, 7, 30, 2);
        check("s2_disp_01", {10'd0, disp}, {10'd0, bcd(7, 30, 1)});
        ring_cnt = 1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (alarm) ring_cnt++;
            else break;
        end
        check("s2_ring_len", ring_cnt, 32'd60);
        check("s2_ring_off", {31'd0, alarm}, 32'd0);

        // Slots 1 and 3 share 06:00: lowest index wins
        write_slot(1, 6, 0, 1'b1);
        write_slot(3, 6, 0, 1'b1);
        do_ring("prio", 5, 59, 6, 0, 1);
        stop_al = 1'b1; step(); stop_al = 1'b0;
        check("prio_stop_alarm", {31'd0, alarm}, 32'd0);
        check("prio_stop_snoozed", {31'd0, snoozed}, 32'd0);

        // Snooze, with the active slot disabled mid-snooze
        do_ring("snz", 5, 59, 6, 0, 1);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("snz_snoozed", {31'd0, snoozed}, 32'd1);
        check("snz_alarm_low", {31'd0, alarm}, 32'd0);
        low_cnt = 1;
        write_slot(1, 6, 0, 1'b0);
        if (!alarm) low_cnt++;
        for (int k = 0; k < 400; k++) begin
            step();
            if (!alarm) low_cnt++;
            else break;
        end
        check("snz_low_len", low_cnt, 32'd300);
        check("snz_reraise", {31'd0, alarm}, 32'd1);
        check("snz_reraise_snoozed", {31'd0, snoozed}, 32'd0);
        check("snz_reraise_idx", {30'd0, alarm_idx}, 32'd1);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("snz2_snoozed", {31'd0, snoozed}, 32'd1);
        stop_al = 1'b1; step(); stop_al = 1'b0;
        check("snz_stop_snoozed", {31'd0, snoozed}, 32'd0);
        check("snz_stop_alarm", {31'd0, alarm}, 32'd0);
        snooze = 1'b1; step(); snooze = 1'b0;
        check("idle_snooze_ignored", {30'd0, snoozed, alarm}, 32'd0);

        // stop_al and snooze together: stop wins; slot 1 now disabled so slot 3 rings
        do_ring("both", 5, 59, 6, 0, 3);
        stop_al = 1'b1; snooze = 1'b1; step(); stop_al = 1'b0; snooze = 1'b0;
        check("both_alarm", {31'd0, alarm}, 32'd0);
        check("both_snoozed", {31'd0, snoozed}, 32'd0);

        // Asynchronous reset mid-ring, mid-second
        do_ring("arst", 5, 59, 6, 0, 3);
        #1 reset = 1'b1;
        #1;
        check("arst_alarm", {31'd0, alarm}, 32'd0);
        check("arst_idx", {30'd0, alarm_idx}, 32'd0);
        check("arst_time", {10'd0, disp}, 32'd0);
        check("arst_flags", {30'd0, snoozed, ld_err}, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk_1s);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
